// File: rtl/serial_sub_ctrl.sv
// Multi-cycle unsigned subtractor: one 2-bit borrow-chained slice stepped
// LSB pair to MSB pair, finishing with a one-cycle done pulse.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("serial_sub_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_r, b_r, res, res_nxt;
    logic             bor_r;
    logic [CW-1:0]    cnt;
    logic [1:0]       d;
    logic             bout;
    logic             last;
    logic             accept;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        // Operands shift right each step, so the active pair is always [1:0].
        {bout, d} = {1'b0, a_r[1:0]} - {1'b0, b_r[1:0]} - {2'b00, bor_r};
        last      = (cnt == CW'(N - 1));
        res_nxt   = res;
        for (int k = 0; k < N; k++) begin
            if (cnt == CW'(k)) res_nxt[2*k +: 2] = d;
        end
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            bor_r      <= 1'b0;
            cnt        <= '0;
            res        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                bor_r <= borrow_in;
                cnt   <= '0;
                res   <= '0;
                diff  <= '0;
            end else if (state == RUN) begin
                a_r   <= a_r >> 2;
                b_r   <= b_r >> 2;
                bor_r <= bout;
                res   <= res_nxt;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    diff       <= res_nxt;
                    borrow_out <= bout;
                    done       <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl at WIDTH=8 and WIDTH=2 with a result scoreboard.
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, bin8, busy8, done8, bo8;
    logic [7:0] a8, b8, diff8;
    logic       start2, bin2, busy2, done2, bo2;
    logic [1:0] a2, b2, diff2;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));

    serial_sub_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .borrow_in(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2));

    int total = 0;
    int bad   = 0;
    logic [8:0] q8[$];
    logic [2:0] q2[$];
    int acc8 = 0, acc2 = 0, dn8 = 0, dn2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain wide arithmetic, top bit is the borrow.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - {8'b0, bi};
    endfunction

    function automatic logic [2:0] model2(input logic [1:0] x, input logic [1:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - {2'b0, bi};
    endfunction

    always @(negedge clk) begin
        if (!rst && done8) begin
            dn8++;
            chk("w8_busy_in_done", {31'b0, busy8}, 32'd0);
            chk("w8_sb_has_entry", {31'b0, q8.size() != 0}, 32'd1);
            if (q8.size() != 0) chk("w8_result", {23'b0, bo8, diff8}, {23'b0, q8.pop_front()});
        end
        if (!rst && done2) begin
            dn2++;
            chk("w2_sb_has_entry", {31'b0, q2.size() != 0}, 32'd1);
            if (q2.size() != 0) chk("w2_result", {29'b0, bo2, diff2}, {29'b0, q2.pop_front()});
        end
    end

    task automatic kick8(input logic [7:0] x, input logic [7:0] y, input logic bi);
        a8 = x; b8 = y; bin8 = bi; start8 = 1'b1;
        q8.push_back(model8(x, y, bi));
        acc8++;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;

    initial begin
        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start2 = 0; a2 = 0; b2 = 0; bin2 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy8}, 32'd0);
        chk("rst_done", {31'b0, done8}, 32'd0);
        chk("rst_diff", {24'b0, diff8}, 32'd0);
        chk("rst_bo",   {31'b0, bo8}, 32'd0);

        // Basic op with cycle-by-cycle busy check.
        kick8(8'h5A, 8'h23, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("op1_busy", {31'b0, busy8}, 32'd1);
            chk("op1_no_done", {31'b0, done8}, 32'd0);
            @(posedge clk); #1;
        end
        chk("op1_done", {31'b0, done8}, 32'd1);
        chk("op1_diff", {24'b0, diff8}, 32'h37);
        @(posedge clk); #1;
        chk("op1_done_pulse", {31'b0, done8}, 32'd0);

        // Full borrow ripple, then the equal-after-borrow and max-borrow cases.
        kick8(8'h00, 8'h01, 1'b0);
        chk("accept_clears_diff", {24'b0, diff8}, 32'd0);
        wait_done8(lat); chk("ripple_lat", lat, 32'd4);
        kick8(8'h10, 8'h0F, 1'b1);
        wait_done8(lat); chk("eq_lat", lat, 32'd4);
        kick8(8'h00, 8'hFF, 1'b1);
        wait_done8(lat); chk("maxb_lat", lat, 32'd4);
        chk("maxb_bo", {31'b0, bo8}, 32'd1);

        // Start during RUN is ignored; start in the done cycle is accepted.
        kick8(8'hC3, 8'h3C, 1'b0);
        @(posedge clk); #1;
        a8 = 8'h11; b8 = 8'h99; bin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(lat); chk("ignored_start_lat", lat, 32'd2);
        kick8(8'h80, 8'h7F, 1'b1);
        chk("b2b_busy", {31'b0, busy8}, 32'd1);
        wait_done8(lat); chk("b2b_lat", lat, 32'd4);
        @(posedge clk); #1;
        chk("no_queued_op", {31'b0, busy8}, 32'd0);

        // Make borrow_out 1, then abort a run with reset.
        kick8(8'h01, 8'h02, 1'b0);
        wait_done8(lat); chk("pre_abort_bo", {31'b0, bo8}, 32'd1);
        kick8(8'h77, 8'h12, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        void'(q8.pop_back());
        acc8--;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy8}, 32'd0);
        chk("abort_diff", {24'b0, diff8}, 32'd0);
        chk("abort_bo",   {31'b0, bo8}, 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_done", {31'b0, done8}, 32'd0);
        end

        // Reset coincident with start drops the start.
        a8 = 8'h44; b8 = 8'h11; start8 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start8 = 1'b0;
        chk("rst_start_busy0", {31'b0, busy8}, 32'd0);
        @(posedge clk); #1;
        chk("rst_start_busy1", {31'b0, busy8}, 32'd0);

        // Random sweep on both widths, issued together.
        for (int n = 0; n < 1000; n++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            a2 = 2'($urandom); b2 = 2'($urandom); bin2 = 1'($urandom);
            q8.push_back(model8(a8, b8, bin8));
            q2.push_back(model2(a2, b2, bin2));
            acc8++; acc2++;
            start8 = 1'b1; start2 = 1'b1;
            @(posedge clk); #1;
            start8 = 1'b0; start2 = 1'b0;
            wait_done8(lat);
            if (lat != 4) chk("rnd_lat8", lat, 32'd4);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count8", dn8, acc8);
        chk("done_count2", dn2, acc2);
        chk("sb_empty8", q8.size(), 32'd0);
        chk("sb_empty2", q2.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Multi-cycle controller that computes an unsigned WIDTH-bit subtraction using one 2-bit borrow-chained subtractor slice, two bits per clock.
- Latches the operands on start, then steps the slice from LSB pair to MSB pair, carrying the borrow in a register between steps.
- Reports the result with a done pulse.
- Sits wherever a wide subtract is needed but area must stay at one 2-bit slice.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be even and >= 2; any other value is an elaboration error. Step count N = WIDTH/2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled with start.
- b  input  WIDTH  subtrahend; sampled with start.
- borrow_in  input  1  initial borrow; sampled with start.
- busy  output  1  high while stepping.
- done  output  1  one-cycle pulse when the result is written.
- diff  output  WIDTH  result, held until the next accepted start.
- borrow_out  output  1  final borrow, held with diff.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - All state updates on the rising edge of clk.
  - rst has priority over every other input.
- Reset values:
  - state=IDLE; busy=0, done=0, diff=0, borrow_out=0.
  - Internal operand registers, borrow register and step counter all cleared to 0.
- State machine (two states):
  - IDLE:
    - If start=1, latch a, b and borrow_in into internal registers and clear the step counter.
    - diff and result shift register clear to 0 on acceptance. borrow_out is unchanged until completion.
    - Go to RUN. busy=1 from the next cycle.
    - If start=0, stay in IDLE and hold outputs.
  - RUN:
    - Each edge processes slice k = step counter (0..N-1) on bits [2k+1:2k]:
      - {bout, d[1:0]} = A2 - B2 - bin, evaluated as a true 3-bit signed result.
      - bout=1 iff A2 < B2 + bin.
    - d is written into result bits [2k+1:2k]. The borrow register takes bout.
    - Either an indexed write or shift-right operands with shift-in at the top of the result is allowed. Both are externally identical.
    - On the edge processing k=N-1:
      - diff gets the full result and borrow_out gets the final bout.
      - done=1 for exactly the following cycle; busy=0 from that cycle; go to IDLE.
- Latency:
  - Exactly N edges from the edge that accepts start to the edge that raises done.
  - busy is high for exactly N cycles.
  - Throughput is one operation per N+... cycles; see back-to-back below.
- Arithmetic contract:
  - diff = (a - b - borrow_in) mod 2^WIDTH.
  - borrow_out = 1 iff a < b + borrow_in, unsigned, with b + borrow_in evaluated in WIDTH+1 bits.
- Boundary conditions:
  - start while busy: ignored. Latched operands are unaffected and no queueing occurs.
  - Input changes on a/b/borrow_in during RUN have no effect.
  - start in the done cycle: state is IDLE, so it is accepted. busy rises the next cycle, giving back-to-back ops with no bubble beyond the done cycle.
  - diff and borrow_out change only on completion, reset, or (diff only) acceptance clear.
  - rst mid-RUN: aborts the operation, returns to reset values next cycle, and no done pulse is issued.
  - rst coincident with start: reset wins and start is dropped.
  - b=0 with borrow_in=0: normal N-cycle run (no shortcut).
  - WIDTH=2: N=1. Single RUN cycle, then done.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, borrow_in=0, start for 1 cycle -> busy high 4 cycles; done 4 edges after accept; diff=0x37, borrow_out=0.
- a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1. Borrow must ripple through all 4 slices.
- a=0x10, b=0x0F, borrow_in=1 -> diff=0x00, borrow_out=0. Then a=0x00, b=0xFF, borrow_in=1 -> diff=0x00, borrow_out=1.
- Pulse start again at cycle 2 of a run, with different operands -> ignored; result matches the first operands. Then assert start in the done cycle -> accepted, and the second result is correct N edges later.
- rst asserted at cycle 2 of a run -> next cycle busy=0, diff=0, borrow_out=0; no done pulse ever appears for the aborted op. rst together with start -> no op starts.
- Randomized sweep, 1000 ops, WIDTH=8 and WIDTH=2 -> every diff/borrow_out matches the arithmetic contract; done count equals accepted start count.
